ic_fetch: RTL and testbench

- Instruction-fetch (IC) stage directly upstream of the decode stage.
- Owns the PC register, drives the synchronous instruction SRAM and produces ic_to_id_bus; the decode stage latches that bus together with the SRAM read data (ic_inst).
- Handles reset vector, sequential fetch, branch redirect, exception/flush redirect, pipeline stall and a pending-redirect register for branches that resolve during a stall.

---
 rtl/ic_fetch.sv | 89 ++++++++
 tb/tb_ic_fetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ic_fetch.sv
// ============================================================================
// Module   : ic_fetch
// Purpose  : IC stage - PC register, instruction SRAM request, ic_to_id_bus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ic_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    output logic [33:0] ic_to_id_bus
);

    localparam logic c_STOP = 1'b1;

    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_pend_valid;
    logic [31:0] r_pend_addr;

    logic [31:0] w_next_pc;
    logic        w_pc_stop;
    logic        w_valid;
    logic        w_adel;
    logic        w_unused_stall;

    assign w_pc_stop      = (stall[0] == c_STOP);
    // stall[1] only freezes decode-side latching; PC hold is driven by stall[0].
    assign w_unused_stall = ^stall[5:1];

    always_comb begin
        w_next_pc = r_pc + PC_STEP;
        if (flush) begin
            w_next_pc = new_pc;
        end else if (br_e && !w_pc_stop) begin
            w_next_pc = br_addr;
        end else if (r_pend_valid && !w_pc_stop) begin
            w_next_pc = r_pend_addr;
        end else if (w_pc_stop) begin
            w_next_pc = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC - PC_STEP;
            r_ce         <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= 32'h0;
        end else begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
            if (flush) begin
                r_pend_valid <= 1'b0;
            end else if (br_e && w_pc_stop) begin
                r_pend_valid <= 1'b1;
                r_pend_addr  <= br_addr;
            end else if (!w_pc_stop) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // The request leaves as soon as reset drops so RESET_PC is actually read
    // in the cycle before it is presented on the bus.
    assign inst_sram_en    = ~rst & (w_next_pc[1:0] == 2'b00);
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = w_next_pc;
    assign inst_sram_wdata = 32'h0;

    assign w_valid      = r_ce & ~flush & ~br_e;
    assign w_adel       = w_valid & (r_pc[1:0] != 2'b00);
    assign ic_to_id_bus = {w_adel, w_valid, r_pc};

endmodule

`default_nettype wire

// File: tb/tb_ic_fetch.sv
// ============================================================================
// Module   : tb_ic_fetch
// Purpose  : Directed self-checking bench for ic_fetch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ic_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [33:0] ic_to_id_bus;

    int tests;
    int failed;

    ic_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .br_e           (br_e),
        .br_addr        (br_addr),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .ic_to_id_bus   (ic_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; stall = 6'd0; flush = 1'b0; br_e = 1'b0;
        new_pc = 32'h0; br_addr = 32'h0;
        repeat (3) step();
        rst = 1'b0;
        #1;
    endtask

    // Advance sequentially until the bus shows target; bounded.
    task automatic goto_pc(input logic [31:0] target);
        int n;
        n = 0;
        while (ic_to_id_bus[31:0] !== target && n < 64) begin
            step(); #1; n++;
        end
        tests++;
        if (ic_to_id_bus[31:0] !== target) begin
            failed++;
            $display("FAIL goto_pc: bus.pc=%h required %h (timeout)", ic_to_id_bus[31:0], target);
        end
    endtask

    task automatic test_reset();
        step();
        rst = 1'b1; stall = 6'd0; flush = 1'b0; br_e = 1'b0;
        new_pc = 32'h0; br_addr = 32'h0;
        step(); #1;
        tests++; if (inst_sram_en !== 1'b0) begin failed++; $display("FAIL rst_en: got %b want 0", inst_sram_en); end
        tests++; if (ic_to_id_bus !== {2'b00, 32'hBFBF_FFFC}) begin failed++; $display("FAIL rst_bus: got %h want %h", ic_to_id_bus, {2'b00, 32'hBFBF_FFFC}); end
        tests++; if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'h0) begin failed++; $display("FAIL rst_tie: wen=%b wdata=%h want 0/0", inst_sram_wen, inst_sram_wdata); end
        step(); step();
        rst = 1'b0;
        #1;
        tests++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0000) begin failed++; $display("FAIL rel1: en=%b addr=%h want 1 bfc00000", inst_sram_en, inst_sram_addr); end
        tests++; if (ic_to_id_bus[32] !== 1'b0) begin failed++; $display("FAIL rel1_valid: got %b want 0", ic_to_id_bus[32]); end
        step(); #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'hBFC0_0000}) begin failed++; $display("FAIL rel2_bus: got %h want %h", ic_to_id_bus, {2'b01, 32'hBFC0_0000}); end
        step(); #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'hBFC0_0004}) begin failed++; $display("FAIL rel3_bus: got %h want %h", ic_to_id_bus, {2'b01, 32'hBFC0_0004}); end
        step(); #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'hBFC0_0008} || inst_sram_addr !== 32'hBFC0_000C) begin failed++; $display("FAIL rel4: bus=%h addr=%h want 1bfc00008 bfc0000c", ic_to_id_bus, inst_sram_addr); end
    endtask

    task automatic test_branch();
        goto_pc(32'hBFC0_0010);
        br_e = 1'b1; br_addr = 32'h8000_0100;
        #1;
        tests++; if (inst_sram_addr !== 32'h8000_0100 || inst_sram_en !== 1'b1) begin failed++; $display("FAIL br_addr: addr=%h en=%b want 80000100 1", inst_sram_addr, inst_sram_en); end
        tests++; if (ic_to_id_bus[32] !== 1'b0) begin failed++; $display("FAIL br_valid: got %b want 0", ic_to_id_bus[32]); end
        step(); br_e = 1'b0; #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'h8000_0100}) begin failed++; $display("FAIL br_bus1: got %h want %h", ic_to_id_bus, {2'b01, 32'h8000_0100}); end
        step(); #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'h8000_0104}) begin failed++; $display("FAIL br_bus2: got %h want %h", ic_to_id_bus, {2'b01, 32'h8000_0104}); end
    endtask

    task automatic test_stall_pending();
        do_reset();
        goto_pc(32'hBFC0_0020);
        stall = 6'b000011; br_e = 1'b1; br_addr = 32'h8000_0200;
        #1;
        tests++; if (inst_sram_addr !== 32'hBFC0_0020 || ic_to_id_bus[32] !== 1'b0) begin failed++; $display("FAIL st0: addr=%h valid=%b want bfc00020 0", inst_sram_addr, ic_to_id_bus[32]); end
        step(); br_e = 1'b0; #1;
        tests++; if (inst_sram_addr !== 32'hBFC0_0020 || ic_to_id_bus !== {2'b01, 32'hBFC0_0020}) begin failed++; $display("FAIL st1: addr=%h bus=%h want bfc00020 1bfc00020", inst_sram_addr, ic_to_id_bus); end
        step(); #1;
        tests++; if (inst_sram_addr !== 32'hBFC0_0020) begin failed++; $display("FAIL st2: addr=%h want bfc00020", inst_sram_addr); end
        step(); stall = 6'd0; #1;
        tests++; if (inst_sram_addr !== 32'h8000_0200 || inst_sram_en !== 1'b1) begin failed++; $display("FAIL st_rel: addr=%h en=%b want 80000200 1", inst_sram_addr, inst_sram_en); end
        step(); #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'h8000_0200} || inst_sram_addr !== 32'h8000_0204) begin failed++; $display("FAIL st_cons: bus=%h addr=%h want 180000200 80000204", ic_to_id_bus, inst_sram_addr); end
    endtask

    task automatic test_pend_overwrite();
        stall = 6'b000011; br_e = 1'b1; br_addr = 32'h8000_0300;
        step(); br_addr = 32'h8000_0400;
        step(); br_e = 1'b0;
        step(); stall = 6'd0; #1;
        tests++; if (inst_sram_addr !== 32'h8000_0400) begin failed++; $display("FAIL pend_ovw: addr=%h want 80000400", inst_sram_addr); end
    endtask

    task automatic test_flush();
        step();
        flush = 1'b1; new_pc = 32'hBFC0_0380; br_e = 1'b1; br_addr = 32'h8000_0000;
        #1;
        tests++; if (inst_sram_addr !== 32'hBFC0_0380 || ic_to_id_bus[32] !== 1'b0) begin failed++; $display("FAIL fl_addr: addr=%h valid=%b want bfc00380 0", inst_sram_addr, ic_to_id_bus[32]); end
        step(); flush = 1'b0; br_e = 1'b0; #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'hBFC0_0380} || inst_sram_addr !== 32'hBFC0_0384) begin failed++; $display("FAIL fl_bus: bus=%h addr=%h want 1bfc00380 bfc00384", ic_to_id_bus, inst_sram_addr); end
        // Flush during a stall must discard a pending branch.
        stall = 6'b000011; br_e = 1'b1; br_addr = 32'h8000_0500;
        step(); br_e = 1'b0; flush = 1'b1; new_pc = 32'hBFC0_0400; #1;
        tests++; if (inst_sram_addr !== 32'hBFC0_0400) begin failed++; $display("FAIL fl_stall: addr=%h want bfc00400", inst_sram_addr); end
        step(); flush = 1'b0; stall = 6'd0; #1;
        tests++; if (inst_sram_addr !== 32'hBFC0_0404) begin failed++; $display("FAIL fl_pend: addr=%h want bfc00404", inst_sram_addr); end
    endtask

    task automatic test_misaligned();
        step();
        br_e = 1'b1; br_addr = 32'h8000_0102; #1;
        tests++; if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'h8000_0102) begin failed++; $display("FAIL mis_en: en=%b addr=%h want 0 80000102", inst_sram_en, inst_sram_addr); end
        step(); br_e = 1'b0; #1;
        tests++; if (ic_to_id_bus !== {2'b11, 32'h8000_0102}) begin failed++; $display("FAIL mis_bus: got %h want %h", ic_to_id_bus, {2'b11, 32'h8000_0102}); end
    endtask

    task automatic test_wrap();
        step();
        br_e = 1'b1; br_addr = 32'hFFFF_FFFC;
        step(); br_e = 1'b0; #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'hFFFF_FFFC} || inst_sram_addr !== 32'h0 || inst_sram_en !== 1'b1) begin failed++; $display("FAIL wrap0: bus=%h addr=%h en=%b want 1fffffffc 0 1", ic_to_id_bus, inst_sram_addr, inst_sram_en); end
        step(); #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'h0} || inst_sram_addr !== 32'h4) begin failed++; $display("FAIL wrap1: bus=%h addr=%h want 100000000 4", ic_to_id_bus, inst_sram_addr); end
    endtask

    task automatic test_reset_midstream();
        step();
        stall = 6'b000011; br_e = 1'b1; br_addr = 32'h8000_0600;
        step(); br_e = 1'b0; rst = 1'b1; #1;
        tests++; if (inst_sram_en !== 1'b0) begin failed++; $display("FAIL mrst_en: got %b want 0", inst_sram_en); end
        step(); rst = 1'b0; stall = 6'd0; #1;
        tests++; if (inst_sram_addr !== 32'hBFC0_0000 || ic_to_id_bus[32] !== 1'b0) begin failed++; $display("FAIL mrst_addr: addr=%h valid=%b want bfc00000 0", inst_sram_addr, ic_to_id_bus[32]); end
        step(); #1;
        tests++; if (ic_to_id_bus !== {2'b01, 32'hBFC0_0000}) begin failed++; $display("FAIL mrst_bus: got %h want %h", ic_to_id_bus, {2'b01, 32'hBFC0_0000}); end
    endtask

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'h0;
        br_e = 1'b0; br_addr = 32'h0;
        test_reset();
        test_branch();
        test_stall_pending();
        test_pend_overwrite();
        test_flush();
        test_misaligned();
        test_wrap();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
